// File: rtl/rvx_irq_ctrl_pkg.sv
// rvx_irq_ctrl_pkg
//   Shared constants for the RVX interrupt controller: register word
//   indices, the CR enable bit position and the "no source" claim ID.
package rvx_irq_ctrl_pkg;

   // Register word indices (rw_address[4:2])
   localparam logic [2:0] REG_CR      = 3'd0;
   localparam logic [2:0] REG_ENABLE  = 3'd1;
   localparam logic [2:0] REG_TRIGGER = 3'd2;
   localparam logic [2:0] REG_PENDING = 3'd3;
   localparam logic [2:0] REG_CLAIM   = 3'd4;

   // Bit position of the global enable inside CR
   localparam int BIT_CR_EN = 0;

   // Claim ID returned when nothing is claimable
   localparam logic [4:0] ID_NONE = 5'd0;

   // Width of a source ID (IDs 1..31, 0 = none)
   localparam int ID_W = 5;

endpackage

// File: rtl/rvx_find_first_set.sv
// rvx_find_first_set
//   Combinational lowest-index priority encoder.
//   Ports:
//     bits        in   WIDTH   request vector
//     found       out  1       at least one bit of 'bits' is set
//     first_index out  IDX_W   index of the lowest set bit (0 when none)
module rvx_find_first_set #(
   parameter int WIDTH = 8,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] bits,
   output logic             found,
   output logic [IDX_W-1:0] first_index
);

   // Scan from the top down so the last hit (lowest index) wins.
   always_comb begin
      found       = 1'b0;
      first_index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (bits[i]) begin
            found       = 1'b1;
            first_index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rvx_irq_ctrl.sv
// rvx_irq_ctrl
//   Memory-mapped interrupt controller. Latches NUM_SOURCES peripheral
//   IRQ lines as level or rising-edge triggered, masks them per source,
//   and drives one registered interrupt line to the core. Software
//   identifies a source by reading CLAIM and retires it by writing its
//   ID back to CLAIM.
//   Ports:
//     clock          in   1            system clock (rising edge)
//     reset_n        in   1            synchronous active-low reset
//     rw_address     in   5            byte address, word = [4:2]
//     read_data      out  32           registered read result
//     read_request   in   1            read strobe
//     read_response  out  1            read acknowledge (1 cycle later)
//     write_data     in   32           write data
//     write_strobe   in   4            byte enables, only 4'b1111 writes
//     write_request  in   1            write strobe
//     write_response out  1            write acknowledge (1 cycle later)
//     irq_sources    in   NUM_SOURCES  peripheral IRQ lines
//     irq            out  1            external interrupt request
module rvx_irq_ctrl
   import rvx_irq_ctrl_pkg::*;
#(
   parameter int NUM_SOURCES = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [4:0]             rw_address,
   output logic [31:0]            read_data,
   input  logic                   read_request,
   output logic                   read_response,
   input  logic [31:0]            write_data,
   input  logic [3:0]             write_strobe,
   input  logic                   write_request,
   output logic                   write_response,
   input  logic [NUM_SOURCES-1:0] irq_sources,
   output logic                   irq
);

   localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   // State
   logic                   cr_en_reg;
   logic [NUM_SOURCES-1:0] enable_reg;
   logic [NUM_SOURCES-1:0] trigger_reg;
   logic [NUM_SOURCES-1:0] pending_e_reg;
   logic [NUM_SOURCES-1:0] pending_e_next;
   logic [NUM_SOURCES-1:0] in_service_reg;
   logic [NUM_SOURCES-1:0] in_service_next;
   logic [NUM_SOURCES-1:0] s_reg;
   logic [NUM_SOURCES-1:0] s_prev_reg;
   logic [31:0]            read_data_reg;
   logic [31:0]            read_data_next;
   logic                   read_response_reg;
   logic                   write_response_reg;
   logic                   irq_reg;

   // Combinational
   logic [NUM_SOURCES-1:0] rise;
   logic [NUM_SOURCES-1:0] pending;
   logic [NUM_SOURCES-1:0] claimable;
   logic [NUM_SOURCES-1:0] claim_mask;
   logic [NUM_SOURCES-1:0] complete_mask;
   logic [NUM_SOURCES-1:0] pend_clr_mask;
   logic                   claim_valid;
   logic [IDX_W-1:0]       claim_idx;
   logic [ID_W-1:0]        claim_id;
   logic                   aligned;
   logic [2:0]             word;
   logic                   wr_ok;
   logic                   rd_ok;
   logic                   rd_claim;
   logic                   complete_hit;
   logic                   pend_wr;

   assign aligned = (rw_address[1:0] == 2'b00);
   assign word    = rw_address[4:2];
   assign rd_ok   = read_request && aligned;
   assign wr_ok   = write_request && aligned && (write_strobe == 4'b1111);

   assign rise      = s_reg & ~s_prev_reg;
   // Edge sources show their latched flop, level sources the live line.
   assign pending   = (trigger_reg & pending_e_reg) | (~trigger_reg & s_reg);
   assign claimable = pending & enable_reg & ~in_service_reg;

   rvx_find_first_set #(
      .WIDTH (NUM_SOURCES),
      .IDX_W (IDX_W)
   ) u_ffs (
      .bits        (claimable),
      .found       (claim_valid),
      .first_index (claim_idx)
   );

   assign claim_id = claim_valid ? (ID_W'(claim_idx) + ID_W'(1)) : ID_NONE;

   // A claim read with nothing claimable has no side effect.
   assign rd_claim     = rd_ok && (word == REG_CLAIM) && claim_valid;
   assign complete_hit = wr_ok && (word == REG_CLAIM) &&
                         (write_data != 32'd0) &&
                         (write_data <= 32'(NUM_SOURCES));
   assign pend_wr      = wr_ok && (word == REG_PENDING);

   // Only edge sources have a clearable pending flop.
   assign pend_clr_mask = pend_wr ? (write_data[NUM_SOURCES-1:0] & trigger_reg)
                                  : '0;

   generate
      for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
         assign claim_mask[gi]    = rd_claim && (claim_idx == IDX_W'(gi));
         assign complete_mask[gi] = complete_hit &&
                                    (write_data[ID_W-1:0] == ID_W'(gi + 1));
      end
   endgenerate

   // Rise is applied after the clears so a same-cycle set wins.
   assign pending_e_next  = (pending_e_reg & ~(claim_mask | pend_clr_mask)) |
                            (rise & trigger_reg);
   assign in_service_next = (in_service_reg & ~complete_mask) | claim_mask;

   // Unaligned reads and reads of words 5..7 hold the previous value.
   always_comb begin
      read_data_next = read_data_reg;
      if (rd_ok) begin
         case (word)
            REG_CR:      read_data_next = 32'(cr_en_reg);
            REG_ENABLE:  read_data_next = 32'(enable_reg);
            REG_TRIGGER: read_data_next = 32'(trigger_reg);
            REG_PENDING: read_data_next = 32'(pending);
            REG_CLAIM:   read_data_next = 32'(claim_id);
            default:     read_data_next = read_data_reg;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cr_en_reg          <= 1'b0;
         enable_reg         <= '0;
         trigger_reg        <= '0;
         pending_e_reg      <= '0;
         in_service_reg     <= '0;
         s_reg              <= '0;
         s_prev_reg         <= '0;
         read_data_reg      <= '0;
         read_response_reg  <= 1'b0;
         write_response_reg <= 1'b0;
         irq_reg            <= 1'b0;
      end else begin
         s_reg              <= irq_sources;
         s_prev_reg         <= s_reg;
         pending_e_reg      <= pending_e_next;
         in_service_reg     <= in_service_next;
         read_data_reg      <= read_data_next;
         read_response_reg  <= read_request;
         write_response_reg <= write_request;
         irq_reg            <= cr_en_reg & (|claimable);
         if (wr_ok) begin
            case (word)
               REG_CR:      cr_en_reg   <= write_data[BIT_CR_EN];
               REG_ENABLE:  enable_reg  <= write_data[NUM_SOURCES-1:0];
               REG_TRIGGER: trigger_reg <= write_data[NUM_SOURCES-1:0];
               default:     ;
            endcase
         end
      end
   end

   assign read_data      = read_data_reg;
   assign read_response  = read_response_reg;
   assign write_response = write_response_reg;
   assign irq            = irq_reg;

endmodule

// File: tb/tb_rvx_irq_ctrl.sv
// tb_rvx_irq_ctrl
//   Self-checking bench for rvx_irq_ctrl: a register-access vector table
//   followed by hand-written interrupt sequences. Read expectations are
//   queued when the request is driven and compared when read_response
//   comes back.
module tb_rvx_irq_ctrl;
   import rvx_irq_ctrl_pkg::*;

   localparam int N = 8;

   logic          clock;
   logic          reset_n;
   logic [4:0]    rw_address;
   logic [31:0]   read_data;
   logic          read_request;
   logic          read_response;
   logic [31:0]   write_data;
   logic [3:0]    write_strobe;
   logic          write_request;
   logic          write_response;
   logic [N-1:0]  irq_sources;
   logic          irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_exp = 32'd0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[17];

   rvx_irq_ctrl #(.NUM_SOURCES(N)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .rw_address     (rw_address),
      .read_data      (read_data),
      .read_request   (read_request),
      .read_response  (read_response),
      .write_data     (write_data),
      .write_strobe   (write_strobe),
      .write_request  (write_request),
      .write_response (write_response),
      .irq_sources    (irq_sources),
      .irq            (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      exp_t e;
      @(posedge clock);
      #1;
      if (read_response === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rd_resp actual=1 required=0");
         end else begin
            e = sb.pop_front();
            $display("rd %s data=%h", e.name, read_data);
            chk(e.name, read_data, e.exp);
         end
      end
   endtask

   task automatic do_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
      exp_t e;
      e.exp  = exp;
      e.name = name;
      rw_address   = addr;
      read_request = 1'b1;
      sb.push_back(e);
      last_exp = exp;
      step();
      read_request = 1'b0;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_resp actual=none required=response", name);
         sb.delete();
      end
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb = 4'hF);
      rw_address    = addr;
      write_data    = data;
      write_strobe  = strb;
      write_request = 1'b1;
      step();
      write_request = 1'b0;
      $display("wr addr=%h data=%h strb=%h", addr, data, strb);
      chk("wr_resp", 32'(write_response), 32'd1);
   endtask

   // One-cycle pulse on the given source mask, then wait until the edge
   // flop is set and irq would be visible.
   task automatic pulse(input logic [N-1:0] m);
      irq_sources = irq_sources | m;
      step();
      irq_sources = irq_sources & ~m;
      step();
      step();
   endtask

   initial begin
      // Register-access table
      vecs[0]  = '{0, 5'h00, 32'h0,        4'hF, 32'h0};
      vecs[1]  = '{0, 5'h04, 32'h0,        4'hF, 32'h0};
      vecs[2]  = '{0, 5'h08, 32'h0,        4'hF, 32'h0};
      vecs[3]  = '{0, 5'h0C, 32'h0,        4'hF, 32'h0};
      vecs[4]  = '{0, 5'h10, 32'h0,        4'hF, 32'h0};
      vecs[5]  = '{1, 5'h04, 32'hFFFFFFFF, 4'hF, 32'h0};
      vecs[6]  = '{0, 5'h04, 32'h0,        4'hF, 32'h000000FF};
      vecs[7]  = '{1, 5'h08, 32'h000000F0, 4'hF, 32'h0};
      vecs[8]  = '{0, 5'h08, 32'h0,        4'hF, 32'h000000F0};
      vecs[9]  = '{1, 5'h00, 32'hFFFFFFFF, 4'hF, 32'h0};
      vecs[10] = '{0, 5'h00, 32'h0,        4'hF, 32'h00000001};
      vecs[11] = '{1, 5'h04, 32'h00000000, 4'h3, 32'h0};
      vecs[12] = '{0, 5'h04, 32'h0,        4'hF, 32'h000000FF};
      vecs[13] = '{1, 5'h04, 32'h0,        4'hF, 32'h0};
      vecs[14] = '{1, 5'h08, 32'h0,        4'hF, 32'h0};
      vecs[15] = '{1, 5'h00, 32'h0,        4'hF, 32'h0};
      vecs[16] = '{0, 5'h04, 32'h0,        4'hF, 32'h0};

      reset_n       = 1'b0;
      rw_address    = 5'h0;
      read_request  = 1'b0;
      write_request = 1'b0;
      write_data    = 32'h0;
      write_strobe  = 4'h0;
      irq_sources   = 8'hFF;

      // Reset with all sources high
      step(); step(); step();
      chk("rst_irq",       32'(irq),            32'd0);
      chk("rst_read_data", read_data,           32'd0);
      chk("rst_rd_resp",   32'(read_response),  32'd0);
      chk("rst_wr_resp",   32'(write_response), 32'd0);
      reset_n     = 1'b1;
      irq_sources = '0;
      step(); step();
      chk("rst_irq_after", 32'(irq), 32'd0);

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         else
            do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Level path on source 0
      do_write(5'h00, 32'h1);
      do_write(5'h04, 32'h1);
      do_write(5'h08, 32'h0);
      irq_sources = 8'h01;
      step();
      chk("lvl_irq_k", 32'(irq), 32'd0);
      step();
      chk("lvl_irq_k1", 32'(irq), 32'd1);
      do_read(5'h10, 32'd1, "lvl_claim");
      step();
      chk("lvl_irq_drop", 32'(irq), 32'd0);
      do_read(5'h0C, 32'h01, "lvl_pending");
      do_write(5'h10, 32'd1);
      chk("lvl_irq_cmp_edge", 32'(irq), 32'd0);
      step();
      chk("lvl_irq_rearm", 32'(irq), 32'd1);
      irq_sources = 8'h00;
      step(); step();
      chk("lvl_irq_src_low", 32'(irq), 32'd0);
      do_read(5'h10, 32'd0, "lvl_claim_none");
      do_write(5'h10, 32'd1);
      step();
      chk("lvl_irq_stays0", 32'(irq), 32'd0);

      // Edge path on source 2
      do_write(5'h04, 32'h4);
      do_write(5'h08, 32'h4);
      irq_sources = 8'h04;
      step();
      irq_sources = 8'h00;
      chk("edge_irq_k", 32'(irq), 32'd0);
      step();
      chk("edge_irq_k1", 32'(irq), 32'd0);
      step();
      chk("edge_irq_k2", 32'(irq), 32'd1);
      do_read(5'h0C, 32'h04, "edge_pend");
      do_read(5'h10, 32'd3,  "edge_claim");
      do_read(5'h0C, 32'h00, "edge_pend_clr");
      chk("edge_irq_claimed", 32'(irq), 32'd0);
      pulse(8'h04);
      do_read(5'h0C, 32'h04, "edge_pend2");
      chk("edge_irq_insvc", 32'(irq), 32'd0);
      do_write(5'h10, 32'd3);
      step();
      chk("edge_irq_after_cmp", 32'(irq), 32'd1);
      do_read(5'h10, 32'd3, "edge_claim2");
      do_write(5'h10, 32'd3);

      // Priority: source 1 edge, source 5 level
      do_write(5'h04, 32'h22);
      do_write(5'h08, 32'h02);
      irq_sources = 8'h20;
      pulse(8'h02);
      do_read(5'h10, 32'd2, "prio_claim_a");
      do_read(5'h10, 32'd6, "prio_claim_b");
      do_read(5'h10, 32'd0, "prio_claim_none");
      pulse(8'h02);
      do_read(5'h10, 32'd0, "prio_claim_insvc");
      do_write(5'h10, 32'd2);
      do_read(5'h10, 32'd2, "prio_reclaim");
      do_write(5'h10, 32'd2);
      do_write(5'h10, 32'd6);
      irq_sources = 8'h00;
      step(); step();

      // Global enable off with a claimable level source
      do_write(5'h00, 32'h0);
      do_write(5'h04, 32'h20);
      do_write(5'h08, 32'h0);
      irq_sources = 8'h20;
      step(); step(); step();
      chk("mask_cr0", 32'(irq), 32'd0);
      do_read(5'h11, last_exp, "unaligned_claim");
      do_read(5'h10, 32'd6, "claim_cr0");
      do_write(5'h10, 32'd6);
      do_write(5'h00, 32'h1);
      step();
      chk("mask_cr1", 32'(irq), 32'd1);
      do_read(5'h14, last_exp, "rd_word5");
      do_read(5'h10, 32'd6, "claim_cr1");
      do_write(5'h10, 32'd6);
      irq_sources = 8'h00;
      step(); step(); step();

      // PENDING write-1-to-clear on an edge source
      do_write(5'h04, 32'h0);
      do_write(5'h08, 32'h4);
      pulse(8'h04);
      do_read(5'h0C, 32'h04, "pend_set");
      do_write(5'h0C, 32'h04);
      do_read(5'h0C, 32'h00, "pend_w1c");

      // Complete of 0 and 9 must be ignored
      do_write(5'h04, 32'h4);
      pulse(8'h04);
      do_read(5'h10, 32'd3, "cmp_setup_claim");
      do_write(5'h10, 32'd0);
      do_write(5'h10, 32'd9);
      pulse(8'h04);
      do_read(5'h10, 32'd0, "cmp_bad_ignored");
      do_write(5'h10, 32'd3);
      do_read(5'h10, 32'd3, "cmp_good");
      do_write(5'h10, 32'd3);

      // Rise in the same cycle as a PENDING clear: set wins
      do_write(5'h04, 32'h0);
      pulse(8'h04);
      irq_sources = 8'h04;
      step();
      do_write(5'h0C, 32'h04);
      irq_sources = 8'h00;
      do_read(5'h0C, 32'h04, "sim_set_wins");
      do_write(5'h0C, 32'h04);
      do_read(5'h0C, 32'h00, "sim_cleared");

      // Reset while source 2 is in service
      do_write(5'h04, 32'h4);
      pulse(8'h04);
      do_read(5'h10, 32'd3, "rst_mid_claim");
      reset_n = 1'b0;
      step(); step();
      reset_n  = 1'b1;
      last_exp = 32'd0;
      chk("rst_mid_irq",   32'(irq), 32'd0);
      chk("rst_mid_rdata", read_data, 32'd0);
      do_read(5'h04, 32'h0, "rst_mid_enable");
      do_write(5'h00, 32'h1);
      do_write(5'h04, 32'h4);
      do_write(5'h08, 32'h4);
      do_read(5'h10, 32'd0, "rst_mid_claim_none");
      pulse(8'h04);
      chk("rst_mid_irq_again", 32'(irq), 32'd1);
      do_read(5'h10, 32'd3, "rst_mid_reclaim");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
